bus_master_arbiter: RTL and testbench

- Shares the single peripheral/memory bus (RAM, LED, Buttom, Switch, Tube, UART, Timer decode) between up to N bus masters: CPU data port, DMA engine and UART boot loader.
- Round-robin grant, per-master burst limit and a lock override.
- Stretches every access to a fixed number of cycles so slow dev_clk peripherals see stable addr/ctrl/data.
- Sits between the masters and the existing address decoder; bus-side tri-state on data stays in the decoder.

---
 rtl/bus_arb_pkg.sv | 23 ++
 rtl/bus_master_arbiter_rr_pick.sv | 28 ++
 rtl/bus_master_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_master_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus master arbiter and its round-robin picker.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } arb_state_t;

  localparam int unsigned DEF_WAIT_CYCLES = 4;
  localparam int unsigned DEF_MAX_BURST   = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  // Outer loop walks priority order last+1, last+2, ...; first hit wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!valid && (j == (32'(last) + i) % N) && req[j]) begin
          valid  = 1'b1;
          winner = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin bus arbiter with burst limit and lock; stretches each beat to WAIT_CYCLES.
module bus_master_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N           = 3,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned MAX_BURST   = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          m_req,
  input  logic [N-1:0]          m_lock,
  input  logic [N*ADDR_W-1:0]   m_addr,
  input  logic [N-1:0]          m_we,
  input  logic [N*DATA_W-1:0]   m_wdata,
  output logic [N-1:0]          m_gnt,
  output logic [N-1:0]          m_ack,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  bus_en,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_we,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic [clog2(N)-1:0]   owner,
  output logic                  busy
);

  localparam int unsigned OW = clog2(N);
  localparam int unsigned BW = clog2(MAX_BURST + 1);
  localparam int unsigned WW = (WAIT_CYCLES > 1) ? clog2(WAIT_CYCLES) : 1;

  arb_state_t          state;
  logic [OW-1:0]       last;
  logic [BW-1:0]       beat_cnt;
  logic [WW-1:0]       wait_cnt;
  logic                pick_valid;
  logic [OW-1:0]       pick_winner;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;
  logic                cont;

  rr_pick #(.N(N), .IDX_W(OW)) u_pick (
    .req    (m_req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    sel_addr  = m_addr[owner*ADDR_W +: ADDR_W];
    sel_wdata = m_wdata[owner*DATA_W +: DATA_W];
    sel_we    = m_we[owner];
    // Lock keeps the bus past the burst limit, but only while the owner still requests.
    cont      = m_req[owner] && (m_lock[owner] || (beat_cnt < BW'(MAX_BURST)));
    busy      = (state != ARB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      m_gnt     <= '0;
      m_ack     <= '0;
      m_rdata   <= '0;
      bus_en    <= 1'b0;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wdata <= '0;
      owner     <= '0;
      last      <= OW'(N - 1);
      beat_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      m_ack <= '0;
      case (state)
        ARB: begin
          if (pick_valid) begin
            owner <= pick_winner;
            m_gnt <= N'(1) << pick_winner;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (m_req[owner]) begin
            bus_addr  <= sel_addr;
            bus_we    <= sel_we;
            bus_wdata <= sel_wdata;
            bus_en    <= 1'b1;
            wait_cnt  <= '0;
            state     <= ACCESS;
          end else begin
            m_gnt <= '0;
            last  <= owner;
            state <= ARB;
          end
        end
        ACCESS: begin
          if (wait_cnt == WW'(WAIT_CYCLES - 1)) begin
            bus_en <= 1'b0;
            if (!bus_we) m_rdata <= bus_rdata;
            if (beat_cnt < BW'(MAX_BURST)) beat_cnt <= beat_cnt + 1'b1;
            m_ack <= m_gnt;
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ACK: begin
          if (cont) begin
            bus_addr  <= sel_addr;
            bus_we    <= sel_we;
            bus_wdata <= sel_wdata;
            bus_en    <= 1'b1;
            wait_cnt  <= '0;
            state     <= ACCESS;
          end else begin
            m_gnt    <= '0;
            last     <= owner;
            beat_cnt <= '0;
            state    <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed self-checking bench for bus_master_arbiter (N=3, WAIT_CYCLES=4, MAX_BURST=8).
module tb_bus_master_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  m_req;
  logic [2:0]  m_lock;
  logic [47:0] m_addr;
  logic [2:0]  m_we;
  logic [23:0] m_wdata;
  logic [2:0]  m_gnt;
  logic [2:0]  m_ack;
  logic [7:0]  m_rdata;
  logic        bus_en;
  logic [15:0] bus_addr;
  logic        bus_we;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic [1:0]  owner;
  logic        busy;

  int unsigned checks;
  int unsigned errors;
  bit          mon_en;

  int unsigned ack_log[$];
  int unsigned gnt_log[$];
  int unsigned gap_log[$];
  int unsigned exp_q[$];

  bus_master_arbiter #(
    .N(3), .ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(4), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_lock(m_lock), .m_addr(m_addr),
    .m_we(m_we), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_ack(m_ack),
    .m_rdata(m_rdata), .bus_en(bus_en), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m_req  = '0;
    m_lock = '0;
    tick();
    tick();
    rst    = 1'b0;
  endtask

  task automatic push_n(input int unsigned v, input int unsigned n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic cmp_q(input string tag, input int unsigned got[$], input int unsigned exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int unsigned i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("gnt_onehot0", {31'd0, $onehot0(m_gnt)}, 32'd1);
      check("bus_en_without_gnt", {31'd0, (bus_en && (m_gnt == 3'b000))}, 32'd0);
    end
  end

  // Requests per master counted in beats; 'single' drops req at each ack and re-raises it one cycle later.
  task automatic run_traffic(input int unsigned r0, input int unsigned r1, input int unsigned r2,
                             input bit single, input bit lock1, input int unsigned unlock_at);
    int unsigned rem[3];
    bit          rearm[3];
    int unsigned n1, zero_run, guard;
    logic [2:0]  prev_gnt;
    rem[0] = r0; rem[1] = r1; rem[2] = r2;
    for (int unsigned i = 0; i < 3; i++) rearm[i] = 1'b0;
    n1 = 0; zero_run = 0; guard = 0; prev_gnt = '0;
    ack_log.delete(); gnt_log.delete(); gap_log.delete();
    m_addr  = {16'h2000, 16'hFF00, 16'h0000};
    m_we    = 3'b010;
    m_wdata = {8'h22, 8'h11, 8'h00};
    m_lock  = {1'b0, lock1, 1'b0};
    for (int unsigned i = 0; i < 3; i++) m_req[i] = (rem[i] != 0);
    while ((rem[0] + rem[1] + rem[2]) != 0 && guard < 1000) begin
      tick();
      guard++;
      if (m_gnt != 3'b000 && prev_gnt == 3'b000) begin
        gnt_log.push_back(32'(owner));
        gap_log.push_back(zero_run);
      end
      zero_run = (m_gnt == 3'b000) ? zero_run + 1 : 0;
      prev_gnt = m_gnt;
      for (int unsigned i = 0; i < 3; i++)
        if (rearm[i]) begin m_req[i] = 1'b1; rearm[i] = 1'b0; end
      for (int unsigned i = 0; i < 3; i++) begin
        if (m_ack[i]) begin
          ack_log.push_back(i);
          if (i == 1) begin
            check("m1_addr", 32'(bus_addr), 32'hFF00);
            check("m1_we", 32'(bus_we), 32'd1);
            n1++;
            if (n1 == unlock_at) m_lock[1] = 1'b0;
          end
          if (rem[i] != 0) rem[i]--;
          if (rem[i] == 0) m_req[i] = 1'b0;
          else if (single) begin m_req[i] = 1'b0; rearm[i] = 1'b1; end
        end
      end
    end
    check("traffic_done", rem[0] + rem[1] + rem[2], 32'd0);
    m_req  = '0;
    m_lock = '0;
    tick();
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mon_en    = 1'b0;
    m_req     = '0;
    m_lock    = '0;
    m_addr    = '0;
    m_we      = '0;
    m_wdata   = '0;
    bus_rdata = '0;
    rst       = 1'b1;

    // Reset values
    tick();
    tick();
    mon_en = 1'b1;
    check("rst_gnt", 32'(m_gnt), 32'd0);
    check("rst_ack", 32'(m_ack), 32'd0);
    check("rst_bus_en", 32'(bus_en), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    check("rst_rdata", 32'(m_rdata), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Single read by master 0
    m_addr[15:0] = 16'h0012;
    m_we[0]      = 1'b0;
    bus_rdata    = 8'hA5;
    m_req        = 3'b001;
    tick();
    check("rd_gnt", 32'(m_gnt), 32'h1);
    check("rd_busy", 32'(busy), 32'd1);
    check("rd_grant_bus_en", 32'(bus_en), 32'd0);
    for (int unsigned c = 0; c < 4; c++) begin
      tick();
      check($sformatf("rd_bus_en_c%0d", c), 32'(bus_en), 32'd1);
      check($sformatf("rd_bus_addr_c%0d", c), 32'(bus_addr), 32'h0012);
      check($sformatf("rd_bus_we_c%0d", c), 32'(bus_we), 32'd0);
      check($sformatf("rd_ack_early_c%0d", c), 32'(m_ack), 32'd0);
    end
    tick();
    check("rd_ack", 32'(m_ack), 32'h1);
    check("rd_rdata", 32'(m_rdata), 32'hA5);
    check("rd_ack_bus_en", 32'(bus_en), 32'd0);
    m_req = 3'b000;
    tick();
    check("rd_ack_pulse", 32'(m_ack), 32'd0);
    check("rd_release_gnt", 32'(m_gnt), 32'd0);
    check("rd_release_busy", 32'(busy), 32'd0);

    // Round robin, single beat each
    do_reset();
    run_traffic(2, 1, 1, 1'b1, 1'b0, 0);
    exp_q.delete(); exp_q = '{0, 1, 2, 0};
    cmp_q("rr_gnt", gnt_log, exp_q);
    cmp_q("rr_ack", ack_log, exp_q);
    for (int unsigned k = 1; k < 4 && k < gap_log.size(); k++)
      check($sformatf("rr_gap%0d", k), gap_log[k], 32'd1);

    // Burst limit forces re-arbitration
    do_reset();
    run_traffic(0, 12, 1, 1'b0, 1'b0, 0);
    exp_q.delete(); push_n(1, 8); push_n(2, 1); push_n(1, 4);
    cmp_q("burst_ack", ack_log, exp_q);
    exp_q.delete(); exp_q = '{1, 2, 1};
    cmp_q("burst_gnt", gnt_log, exp_q);

    // Lock held for the whole stream
    do_reset();
    run_traffic(0, 12, 1, 1'b0, 1'b1, 0);
    exp_q.delete(); push_n(1, 12); push_n(2, 1);
    cmp_q("lock_ack", ack_log, exp_q);

    // Lock dropped past the limit releases at the next ack
    do_reset();
    run_traffic(0, 12, 1, 1'b0, 1'b1, 10);
    exp_q.delete(); push_n(1, 10); push_n(2, 1); push_n(1, 2);
    cmp_q("unlock_ack", ack_log, exp_q);

    // Write with req dropped mid-access; non-owner activity must not disturb the bus
    do_reset();
    m_addr        = '0;
    m_addr[15:0]  = 16'h0040;
    m_we          = 3'b001;
    m_wdata       = '0;
    m_wdata[7:0]  = 8'h5A;
    bus_rdata     = 8'hC3;
    m_req         = 3'b001;
    tick();
    tick();
    check("wr_bus_en_c0", 32'(bus_en), 32'd1);
    check("wr_wdata_c0", 32'(bus_wdata), 32'h5A);
    m_req          = 3'b100;
    m_addr[47:32]  = 16'hBEEF;
    m_wdata[7:0]   = 8'h00;
    m_wdata[23:16] = 8'hFF;
    for (int unsigned c = 1; c < 4; c++) begin
      tick();
      check($sformatf("wr_bus_en_c%0d", c), 32'(bus_en), 32'd1);
      check($sformatf("wr_wdata_c%0d", c), 32'(bus_wdata), 32'h5A);
      check($sformatf("wr_addr_c%0d", c), 32'(bus_addr), 32'h0040);
      check($sformatf("wr_we_c%0d", c), 32'(bus_we), 32'd1);
    end
    tick();
    check("wr_ack", 32'(m_ack), 32'h1);
    check("wr_rdata_kept", 32'(m_rdata), 32'd0);
    tick();
    check("wr_release_gnt", 32'(m_gnt), 32'd0);
    m_req = 3'b000;
    tick();

    // Reset during the second access cycle
    do_reset();
    m_addr    = '0;
    m_we      = 3'b000;
    bus_rdata = 8'h77;
    m_req     = 3'b001;
    tick();
    tick();
    tick();
    check("ra_in_access", 32'(bus_en), 32'd1);
    rst = 1'b1;
    tick();
    check("ra_bus_en", 32'(bus_en), 32'd0);
    check("ra_gnt", 32'(m_gnt), 32'd0);
    check("ra_ack", 32'(m_ack), 32'd0);
    check("ra_rdata", 32'(m_rdata), 32'd0);
    rst   = 1'b0;
    m_req = 3'b111;
    tick();
    check("ra_first_gnt", 32'(m_gnt), 32'h1);
    check("ra_first_owner", 32'(owner), 32'd0);
    m_req = 3'b000;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
